// File: rtl/esm_dwell_sequencer.sv
// esm_dwell_sequencer: programmable dwell sequencer driving AD9361 fast-lock and timing each dwell.
// Optional tune statistics ports are enabled by defining ESM_DWELL_SEQ_TUNE_STATS_EN.
module esm_dwell_sequencer #(
  parameter int NUM_ENTRIES    = 32,
  parameter int NUM_PROGRAM    = 64,
  parameter int METADATA_WIDTH = 192,
  parameter int GUARD_CYCLES   = 4,
  parameter int TUNE_TIMEOUT   = 1024
) (
  input  logic                           Clk,
  input  logic                           Rst_n,
  input  logic                           Enable,
  input  logic                           Entry_wr_valid,
  input  logic [$clog2(NUM_ENTRIES)-1:0] Entry_wr_index,
  input  logic [31:0]                    Entry_wr_duration,
  input  logic [2:0]                     Entry_wr_profile,
  input  logic [METADATA_WIDTH-1:0]      Entry_wr_metadata,
  input  logic                           Prog_wr_valid,
  input  logic [$clog2(NUM_PROGRAM)-1:0] Prog_wr_index,
  input  logic [$clog2(NUM_ENTRIES)-1:0] Prog_wr_entry,
  input  logic [7:0]                     Prog_wr_repeat,
  input  logic [$clog2(NUM_PROGRAM):0]   Prog_length,
  output logic [3:0]                     Ad9361_control,
  input  logic [7:0]                     Ad9361_status,
  output logic                           Dwell_active,
  output logic [METADATA_WIDTH-1:0]      Dwell_data,
  output logic                           Dwell_done,
  output logic [15:0]                    Dwell_seq_num,
  output logic                           Program_wrap,
  output logic                           Tune_error
`ifdef ESM_DWELL_SEQ_TUNE_STATS_EN
  ,
  output logic [15:0]                    Dwell_tune_cycles,
  output logic [15:0]                    Tune_error_count
`endif
);
  localparam int EW = $clog2(NUM_ENTRIES);
  localparam int PW = $clog2(NUM_PROGRAM);
  localparam logic [2:0] S_IDLE = 3'd0, S_LOAD = 3'd1, S_LOAD_E = 3'd2, S_TUNE = 3'd3,
                         S_LOCK = 3'd4, S_DWELL = 3'd5, S_NEXT = 3'd6;
  localparam logic [31:0] GUARD_LAST = 32'(GUARD_CYCLES - 1);
  localparam logic [31:0] LOCK_LAST  = 32'(TUNE_TIMEOUT - 1);

  logic [31:0]               dur_mem  [NUM_ENTRIES];
  logic [2:0]                prof_mem [NUM_ENTRIES];
  logic [METADATA_WIDTH-1:0] meta_mem [NUM_ENTRIES];
  logic [EW-1:0]             ent_mem  [NUM_PROGRAM];
  logic [7:0]                rep_mem  [NUM_PROGRAM];

  logic [EW-1:0]             ent_rd_q;
  logic [7:0]                rep_rd_q;
  logic [31:0]               dur_q;
  logic [2:0]                prof_q;
  logic [METADATA_WIDTH-1:0] meta_q;

  logic [2:0]                state_q, state_d;
  logic [PW-1:0]             ptr_q, ptr_d;
  logic [PW:0]               len_q, len_d;
  logic [7:0]                rep_q, rep_d;
  logic [3:0]                ctrl_q, ctrl_d;
  logic [METADATA_WIDTH-1:0] data_q, data_d;
  logic [15:0]               seq_q, seq_d;
  logic                      terr_q, terr_d;
  logic [31:0]               cnt_q, cnt_d;
  logic                      locked, dwell_last, wrap;

  // Program read then entry read; a same-cycle write still returns the old word.
  always_ff @(posedge Clk) begin
    if (Entry_wr_valid) begin
      dur_mem[Entry_wr_index]  <= Entry_wr_duration;
      prof_mem[Entry_wr_index] <= Entry_wr_profile;
      meta_mem[Entry_wr_index] <= Entry_wr_metadata;
    end
    if (Prog_wr_valid) begin
      ent_mem[Prog_wr_index] <= Prog_wr_entry;
      rep_mem[Prog_wr_index] <= Prog_wr_repeat;
    end
    if (state_q == S_LOAD) begin
      ent_rd_q <= ent_mem[ptr_q];
      rep_rd_q <= rep_mem[ptr_q];
    end
    if (state_q == S_LOAD_E) begin
      dur_q  <= dur_mem[ent_rd_q];
      prof_q <= prof_mem[ent_rd_q];
      meta_q <= meta_mem[ent_rd_q];
    end
  end

  assign locked     = Ad9361_status == 8'hFF;
  assign dwell_last = dur_q == 32'd0 || cnt_q == dur_q - 32'd1;
  assign wrap       = rep_q == 8'd0 && {1'b0, ptr_q} == len_q - 1'b1;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    rep_d   = rep_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    seq_d   = seq_q;
    terr_d  = 1'b0;
    case (state_q)
      S_IDLE:
        if (Enable && Prog_length != '0) begin
          state_d = S_LOAD;
          len_d   = Prog_length;
          ptr_d   = '0;
        end
      S_LOAD: state_d = S_LOAD_E;
      S_LOAD_E: begin
        state_d = S_TUNE;
        rep_d   = rep_rd_q;
        ctrl_d  = {~ctrl_q[3], prof_mem[ent_rd_q]};
      end
      S_TUNE: state_d = cnt_q == GUARD_LAST ? S_LOCK : S_TUNE;
      S_LOCK:
        if (locked || cnt_q == LOCK_LAST) begin
          state_d = S_DWELL;
          data_d  = meta_q;
          terr_d  = !locked;
        end
      S_DWELL:
        if (dwell_last) begin
          state_d = S_NEXT;
          seq_d   = seq_q + 16'd1;
        end
      S_NEXT: begin
        rep_d   = rep_q != 8'd0 ? rep_q - 8'd1 : rep_q;
        ptr_d   = rep_q != 8'd0 ? ptr_q : wrap ? '0 : ptr_q + 1'b1;
        state_d = !Enable ? S_IDLE : rep_q != 8'd0 ? S_TUNE : S_LOAD;
        ctrl_d  = Enable && rep_q != 8'd0 ? {~ctrl_q[3], prof_q} : ctrl_q;
      end
      default: state_d = S_IDLE;
    endcase
    cnt_d = state_d != state_q ? 32'd0 : cnt_q + 32'd1;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      len_q   <= '0;
      rep_q   <= '0;
      ctrl_q  <= '0;
      data_q  <= '0;
      seq_q   <= '0;
      terr_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      rep_q   <= rep_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
      seq_q   <= seq_d;
      terr_q  <= terr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Ad9361_control = ctrl_q;
  assign Dwell_active   = state_q == S_DWELL;
  assign Dwell_data     = data_q;
  assign Dwell_done     = state_q == S_NEXT;
  assign Dwell_seq_num  = seq_q;
  assign Program_wrap   = state_q == S_NEXT && wrap;
  assign Tune_error     = terr_q;

`ifdef ESM_DWELL_SEQ_TUNE_STATS_EN
  logic [15:0] tcyc_q, tcyc_d, ecnt_q, ecnt_d;
  logic [32:0] tsum;
  // Cycles spent in tune plus lock, counted at the lock exit.
  assign tsum = 33'(GUARD_CYCLES) + {1'b0, cnt_q} + 33'd1;
  always_comb begin
    tcyc_d = state_q == S_LOCK && state_d == S_DWELL ? (|tsum[32:16] ? 16'hFFFF : tsum[15:0]) : tcyc_q;
    ecnt_d = terr_d && ecnt_q != 16'hFFFF ? ecnt_q + 16'd1 : ecnt_q;
  end
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      tcyc_q <= '0;
      ecnt_q <= '0;
    end else begin
      tcyc_q <= tcyc_d;
      ecnt_q <= ecnt_d;
    end
  end
  assign Dwell_tune_cycles = tcyc_q;
  assign Tune_error_count  = ecnt_q;
`endif
endmodule

// File: tb/tb_esm_dwell_sequencer.sv
// tb_esm_dwell_sequencer: directed/randomized bench with a schedule-level reference model.
module tb_esm_dwell_sequencer;
  localparam int NE = 32, NP = 64, MW = 192, G = 4, T = 1024;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          e_wv = 1'b0;
  logic [4:0]    e_wi = '0;
  logic [31:0]   e_wd = '0;
  logic [2:0]    e_wp = '0;
  logic [MW-1:0] e_wm = '0;
  logic          p_wv = 1'b0;
  logic [5:0]    p_wi = '0;
  logic [4:0]    p_we = '0;
  logic [7:0]    p_wr = '0;
  logic [6:0]    plen_in = '0;
  logic [3:0]    ctrl;
  logic [7:0]    status = '0;
  logic          active, done, wrap, terr;
  logic [MW-1:0] data;
  logic [15:0]   seq;
`ifdef ESM_DWELL_SEQ_TUNE_STATS_EN
  logic [15:0]   tcyc, ecnt;
  int            m_ecnt = 0;
`endif

  esm_dwell_sequencer dut (
    .Clk(clk), .Rst_n(rst_n), .Enable(en),
    .Entry_wr_valid(e_wv), .Entry_wr_index(e_wi), .Entry_wr_duration(e_wd),
    .Entry_wr_profile(e_wp), .Entry_wr_metadata(e_wm),
    .Prog_wr_valid(p_wv), .Prog_wr_index(p_wi), .Prog_wr_entry(p_we), .Prog_wr_repeat(p_wr),
    .Prog_length(plen_in), .Ad9361_control(ctrl), .Ad9361_status(status),
    .Dwell_active(active), .Dwell_data(data), .Dwell_done(done), .Dwell_seq_num(seq),
    .Program_wrap(wrap), .Tune_error(terr)
`ifdef ESM_DWELL_SEQ_TUNE_STATS_EN
    , .Dwell_tune_cycles(tcyc), .Tune_error_count(ecnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  logic [31:0]   e_dur  [NE];
  logic [2:0]    e_prof [NE];
  logic [MW-1:0] e_meta [NE];
  int            p_ent  [NP];
  int            p_rep  [NP];
  logic [31:0]   l_dur;
  logic [2:0]    l_prof;
  logic [MW-1:0] l_meta;

  typedef struct {int ent; bit fresh; bit last;} step_t;
  step_t sched[$];
  int    pos = 0;
  logic [15:0] m_seq = '0;
  bit    m_tog = 1'b0;
  bit    lock_en = 1'b1;
  int    lock_delay = 0;

  // Radio model: reports lock lock_delay cycles after each control change, noise otherwise.
  int since = 0;
  logic [3:0] prev_ctrl = '0;
  always @(negedge clk) begin
    since = ctrl !== prev_ctrl ? 0 : since + 1;
    prev_ctrl = ctrl;
    status = lock_en && since >= lock_delay ? 8'hFF : 8'($urandom_range(0, 254));
  end

  task automatic chk(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [MW-1:0] rand_meta();
    logic [MW-1:0] m;
    for (int w = 0; w < MW / 32; w++) m[w*32 +: 32] = $urandom;
    return m;
  endfunction

  task automatic wr_entry(input int i, input logic [31:0] d);
    @(negedge clk);
    e_wv = 1'b1; e_wi = 5'(i); e_wd = d; e_wp = 3'($urandom); e_wm = rand_meta();
    e_dur[i] = e_wd; e_prof[i] = e_wp; e_meta[i] = e_wm;
    @(negedge clk);
    e_wv = 1'b0;
  endtask

  task automatic wr_prog(input int i, input int e, input int r);
    @(negedge clk);
    p_wv = 1'b1; p_wi = 6'(i); p_we = 5'(e); p_wr = 8'(r);
    p_ent[i] = e; p_rep[i] = r;
    @(negedge clk);
    p_wv = 1'b0;
  endtask

  task automatic start(input int len);
    sched.delete();
    for (int s = 0; s < len; s++)
      for (int r = 0; r <= p_rep[s]; r++)
        sched.push_back('{p_ent[s], r == 0, s == len - 1 && r == p_rep[s]});
    pos = 0;
    @(negedge clk);
    plen_in = 7'(len);
    en = 1'b1;
  endtask

  task automatic run_dwells(input int n, input int drop_at, input bit hazard);
    for (int k = 0; k < n; k++) begin
      step_t st = sched[pos];
      logic [3:0] c0 = ctrl;
      int w = 0, iv = 0, a = 0, bad = 0, eff, exp_iv;
      bit exp_err;
      while (ctrl === c0 && w < 3000) begin @(negedge clk); w++; end
      chk("ctrl_change", 1'(w < 3000), 1'b1);
      if (st.fresh) begin
        l_dur = e_dur[st.ent]; l_prof = e_prof[st.ent]; l_meta = e_meta[st.ent];
      end
      m_tog = ~m_tog;
      chk("control", ctrl, {m_tog, l_prof});
      while (!active && iv < 3000) begin @(negedge clk); iv++; end
      eff = lock_en ? (lock_delay > G ? lock_delay : G) : G + T;
      exp_err = eff > G + T - 1;
      exp_iv = exp_err ? G + T : eff + 1;
      chk("tune_interval", iv, exp_iv);
      chk("tune_error", terr, exp_err);
      chk("dwell_data", data, l_meta);
`ifdef ESM_DWELL_SEQ_TUNE_STATS_EN
      if (exp_err) m_ecnt++;
      chk("tune_cycles", tcyc, iv);
      chk("error_count", ecnt, m_ecnt);
`endif
      while (active && a < 100000) begin
        if (data !== l_meta || done) bad++;
        if (hazard && k == 0 && a == 3) begin
          e_wv = 1'b1; e_wi = 5'(st.ent); e_wd = 32'($urandom_range(1, 20));
          e_wp = 3'($urandom); e_wm = rand_meta();
          e_dur[st.ent] = e_wd; e_prof[st.ent] = e_wp; e_meta[st.ent] = e_wm;
        end
        if (a == 4) e_wv = 1'b0;
        if (k == n - 1 && a == drop_at) en = 1'b0;
        @(negedge clk);
        a++;
      end
      e_wv = 1'b0;
      chk("dwell_len", a, l_dur == 0 ? 1 : l_dur);
      chk("dwell_stable", bad, 0);
      m_seq++;
      chk("done", done, 1'b1);
      chk("seq_num", seq, m_seq);
      chk("program_wrap", wrap, st.last);
      chk("tune_error_pulse", terr, 1'b0);
      pos = (pos + 1) % sched.size();
    end
    if (drop_at >= 0) begin
      logic [3:0] c1 = ctrl;
      int bad = 0;
      repeat (20) begin
        @(negedge clk);
        if (ctrl !== c1 || active || done) bad++;
      end
      chk("idle_after_drop", bad, 0);
    end
  endtask

  initial begin
    int bad, len, w;
    logic [3:0] c0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {ctrl, active, |data, done, seq, wrap, terr}, '0);
    rst_n = 1'b1;

    en = 1'b1; plen_in = '0; bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (ctrl != 0 || active || data != 0 || done || seq != 0 || wrap || terr) bad++;
    end
    chk("len0_idle", bad, 0);
    en = 1'b0;

    wr_entry(0, 10); wr_prog(0, 0, 0);
    lock_en = 1'b1; lock_delay = 20;
    start(1); run_dwells(3, 4, 1'b0);

    wr_entry(3, 32'($urandom_range(1, 12))); wr_entry(5, 32'($urandom_range(1, 12)));
    wr_prog(0, 3, 2); wr_prog(1, 5, 0);
    lock_delay = $urandom_range(0, 30);
    start(2); run_dwells(8, 0, 1'b0);

    for (int i = 0; i < NE; i++) wr_entry(i, 32'($urandom_range(0, 20)));
    len = $urandom_range(3, 8);
    for (int s = 0; s < len; s++) wr_prog(s, $urandom_range(0, NE - 1), $urandom_range(0, 2));
    lock_delay = $urandom_range(0, 15);
    start(len);
    @(negedge clk);
    plen_in = 7'($urandom);
    run_dwells(15, 0, 1'b0);

    wr_entry(7, 0); wr_prog(0, 7, 1);
    lock_delay = 0;
    start(1); run_dwells(3, 0, 1'b0);

    lock_en = 1'b0;
    wr_entry(0, 8); wr_prog(0, 0, 0);
    start(1); run_dwells(2, 0, 1'b0);
    lock_en = 1'b1;

    for (int i = 0; i < NE; i++) wr_entry(i, 32'($urandom_range(0, 2)));
    for (int s = 0; s < NP; s++) wr_prog(s, $urandom_range(0, NE - 1), 0);
    start(64); run_dwells(66, 0, 1'b0);

    wr_entry(2, 500); wr_prog(0, 2, 0);
    start(1); run_dwells(1, 100, 1'b0);

    wr_entry(0, 15); wr_prog(0, 0, 0);
    lock_delay = 3;
    start(1); run_dwells(3, 0, 1'b1);

    wr_entry(1, 3); wr_entry(2, 4); wr_prog(0, 1, 0); wr_prog(1, 2, 0);
    lock_delay = 0;
    start(2); run_dwells(1, -1, 1'b0);
    lock_en = 1'b0;
    c0 = ctrl; w = 0;
    while (ctrl === c0 && w < 3000) begin @(negedge clk); w++; end
    chk("lock_wait_ctrl", 1'(w < 3000), 1'b1);
    repeat (G + 5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs", {ctrl, active, |data, done, seq, wrap, terr}, '0);
    en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_seq = '0; m_tog = 1'b0; lock_en = 1'b1;
`ifdef ESM_DWELL_SEQ_TUNE_STATS_EN
    m_ecnt = 0;
`endif
    start(2); run_dwells(2, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
